test_monitor: RTL and testbench

- Bus-snooping test-completion monitor that sits on the CPU's data-memory write bus beside data_memory in simulation and FPGA self-test builds.
- Captures stores to NUM_CHECKS result slots and detects a tohost end-of-program store.
- Compares captured slots against expected values, then reports pass/fail, exit code, cycle count and timeout.
- Replaces hard-coded end-of-run memory peeks and fixed run lengths with a parametrised, event-driven checker.

---
 rtl/test_monitor.sv | 191 +++++++++++++++++++
 tb/tb_test_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// test_monitor: snoops data-memory stores, captures result slots and grades the run on a tohost store.
// Optional out-of-range store trap enabled by defining TEST_MONITOR_OOB_EN.
module test_monitor #(
    parameter int          NUM_CHECKS     = 4,
    parameter logic [31:0] CHECK_BASE     = 32'h0000_0200,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_03FC,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          MEM_SIZE_BYTES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic [31:0]              wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [32*NUM_CHECKS-1:0] exp_data,
    input  logic [NUM_CHECKS-1:0]    exp_mask,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [30:0]              exit_code,
    output logic [3:0]               fail_idx,
    output logic [31:0]              fail_got,
    output logic [31:0]              cycle_count,
    output logic [NUM_CHECKS-1:0]    slot_written,
    output logic                     oob_err
);

    localparam logic [29:0] BASE_WORD    = CHECK_BASE[31:2];
    localparam logic [29:0] TOHOST_WORD  = TOHOST_ADDR[31:2];
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MEM_LIMIT    = 32'(MEM_SIZE_BYTES);
    localparam logic [3:0]  LAST_IDX     = 4'(NUM_CHECKS - 1);

`ifdef TEST_MONITOR_OOB_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [31:0]           slots [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] slot_hit;
    logic                  tohost_hit;
    logic                  timeout_hit;
    logic                  oob_hit;
    logic                  check_fail;
    logic                  fail_found;
    logic [3:0]            check_idx;
    logic                  sel_mask;
    logic                  sel_written;
    logic [31:0]           sel_slot;
    logic [31:0]           sel_exp;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int j = 0; j < 4; j++) begin
            if (strb[j]) r[8*j +: 8] = new_v[8*j +: 8];
        end
        return r;
    endfunction

    // Slot under inspection during CHECK, selected without a variable-width index.
    always_comb begin
        sel_mask    = 1'b0;
        sel_written = 1'b0;
        sel_slot    = '0;
        sel_exp     = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (check_idx == 4'(i)) begin
                sel_mask    = exp_mask[i];
                sel_written = slot_written[i];
                sel_slot    = slots[i];
                sel_exp     = exp_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        next_state  = state;
        slot_hit    = '0;
        tohost_hit  = 1'b0;
        timeout_hit = 1'b0;
        oob_hit     = 1'b0;
        check_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                oob_hit     = OOB_EN && wr_en && (wr_addr >= MEM_LIMIT);
                tohost_hit  = wr_en && (wr_addr[31:2] == TOHOST_WORD) &&
                              (wr_strb != 4'b0000) && wr_data[0];
                timeout_hit = (cycle_count == TIMEOUT_LAST);
                if (!oob_hit) begin
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        slot_hit[i] = wr_en && (wr_addr[31:2] == BASE_WORD + 30'(i));
                    end
                end
                // An out-of-range store outranks tohost and timeout; tohost outranks timeout.
                if (oob_hit)          next_state = DONE;
                else if (tohost_hit)  next_state = CHECK;
                else if (timeout_hit) next_state = DONE;
            end
            CHECK: begin
                check_fail = sel_mask && (!sel_written || (sel_slot != sel_exp));
                if (check_idx == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) slots[i] <= '0;
            slot_written <= '0;
            cycle_count  <= '0;
            exit_code    <= '0;
            check_idx    <= '0;
            fail_found   <= 1'b0;
            fail_idx     <= '0;
            fail_got     <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            oob_err      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        if (slot_hit[i]) begin
                            slots[i]        <= merge_bytes(slots[i], wr_data, wr_strb);
                            slot_written[i] <= 1'b1;
                        end
                    end
                    if (oob_hit) begin
                        oob_err    <= 1'b1;
                        fail_found <= 1'b1;
                        fail_idx   <= 4'hF;
                        fail_got   <= wr_addr;
                    end else if (tohost_hit) begin
                        exit_code <= wr_data[31:1];
                        check_idx <= '0;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                    end
                end
                CHECK: begin
                    check_idx <= check_idx + 4'd1;
                    // Only the first failing slot is reported; the scan still covers every slot.
                    if (check_fail && !fail_found) begin
                        fail_found <= 1'b1;
                        fail_idx   <= check_idx;
                        fail_got   <= sel_slot;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    pass <= !fail_found && (exit_code == 31'd0) && !timeout && !oob_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: a rule-level model of the run is compared every cycle,
// and hand-computed literals pin the key results of each scenario.
module tb_test_monitor;

    localparam int N   = 4;
    localparam int TMO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            wr_en = 1'b0;
    logic [31:0]     wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic [3:0]      wr_strb = '0;
    logic [32*N-1:0] exp_data = '0;
    logic [N-1:0]    exp_mask = '0;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [30:0]     exit_code;
    logic [3:0]      fail_idx;
    logic [31:0]     fail_got;
    logic [31:0]     cycle_count;
    logic [N-1:0]    slot_written;
    logic            oob_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    test_monitor #(
        .NUM_CHECKS     (N),
        .CHECK_BASE     (32'h0000_0200),
        .TOHOST_ADDR    (32'h0000_03FC),
        .TIMEOUT_CYCLES (TMO),
        .MEM_SIZE_BYTES (1024)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .exp_data     (exp_data),
        .exp_mask     (exp_mask),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .exit_code    (exit_code),
        .fail_idx     (fail_idx),
        .fail_got     (fail_got),
        .cycle_count  (cycle_count),
        .slot_written (slot_written),
        .oob_err      (oob_err)
    );

    // Model of the run: kind 1 = ended by tohost, 2 = by timeout, 3 = by out-of-range store.
    int          edge_n = 0;
    bit          m_active = 0;
    bit          m_ended = 0;
    bit          m_oob = 0;
    int          m_kind = 0;
    int          m_end_edge = 0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_slot [N];
    logic [N-1:0] m_wr = '0;
    logic [30:0] m_exit = '0;
    logic [31:0] m_oob_addr = '0;

    always @(posedge clk) begin : model
        logic [31:0] prev;
        bit          is_oob;
        edge_n++;
        if (reset) begin
            m_active = 0; m_ended = 0; m_oob = 0; m_kind = 0;
            m_cyc = '0; m_wr = '0; m_exit = '0; m_oob_addr = '0;
            for (int i = 0; i < N; i++) m_slot[i] = '0;
        end else if (m_active) begin
            prev = m_cyc;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            is_oob = 0;
`ifdef TEST_MONITOR_OOB_EN
            is_oob = wr_en && (wr_addr >= 32'd1024);
`endif
            if (is_oob) begin
                m_oob = 1; m_oob_addr = wr_addr;
                m_active = 0; m_ended = 1; m_kind = 3; m_end_edge = edge_n;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (wr_en && (wr_addr[31:2] == 30'h80 + 30'(i))) begin
                        for (int b = 0; b < 4; b++)
                            if (wr_strb[b]) m_slot[i][8*b +: 8] = wr_data[8*b +: 8];
                        m_wr[i] = 1'b1;
                    end
                end
                if (wr_en && (wr_addr[31:2] == 30'hFF) && (wr_strb != 0) && wr_data[0]) begin
                    m_exit = wr_data[31:1];
                    m_active = 0; m_ended = 1; m_kind = 1; m_end_edge = edge_n;
                end else if (prev == 32'(TMO - 1)) begin
                    m_active = 0; m_ended = 1; m_kind = 2; m_end_edge = edge_n;
                end
            end
        end else if (!m_ended && start) begin
            m_active = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic compare_cycle();
        bit          e_done, p, found;
        int          lat;
        logic [3:0]  fi;
        logic [31:0] fg;
        logic [30:0] ex;
        lat    = (m_kind == 1) ? N + 1 : 1;
        e_done = m_ended && ((edge_n - m_end_edge) >= lat);
        chk("cycle_count", cycle_count, m_cyc);
        chk("slot_written", 32'(slot_written), 32'(m_wr));
        chk("timeout_flag", 32'(timeout), 32'(m_kind == 2));
        chk("oob_err", 32'(oob_err), 32'(m_oob));
        chk("done", 32'(done), 32'(e_done));
        if (e_done) begin
            p = 0; found = 0; fi = '0; fg = '0; ex = '0;
            if (m_kind == 1) begin
                p = (m_exit == 0);
                ex = m_exit;
                for (int i = 0; i < N; i++) begin
                    if (exp_mask[i] && (!m_wr[i] || (m_slot[i] != exp_data[32*i +: 32]))) begin
                        p = 0;
                        if (!found) begin found = 1; fi = 4'(i); fg = m_slot[i]; end
                    end
                end
            end else if (m_kind == 3) begin
                fi = 4'hF; fg = m_oob_addr;
            end
            chk("pass", 32'(pass), 32'(p));
            chk("exit_code", 32'(exit_code), 32'(ex));
            chk("fail_idx", 32'(fail_idx), 32'(fi));
            chk("fail_got", fail_got, fg);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) chk("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic run_merge(input logic [31:0] expv, output int k);
        do_reset();
        exp_data = '0; exp_data[31:0] = expv; exp_mask = 4'b0001;
        pulse_start();
        store(32'h201, 32'h0000_3400, 4'b0010);
        store(32'h200, 32'h0000_0012, 4'b0001);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);

        // Pass path, with a store in IDLE that must be ignored.
        do_reset();
        exp_data = '0; exp_data[31:0] = 32'h69; exp_mask = 4'b0001;
        store(32'h200, 32'hDEAD_BEEF, 4'hF);
        chk("idle_store_ignored", 32'(slot_written), 32'd0);
        pulse_start();
        store(32'h200, 32'h69, 4'hF);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
        chk("pass_latency", 32'(k), 32'd5);
        chk("pass_lit", 32'(pass), 32'd1);
        chk("pass_exit", 32'(exit_code), 32'd0);

        // Byte merge, matching then mismatching expectation.
        run_merge(32'h0000_3412, k);
        chk("merge_pass", 32'(pass), 32'd1);
        run_merge(32'h0000_3413, k);
        chk("merge_fail_pass", 32'(pass), 32'd0);
        chk("merge_fail_idx", 32'(fail_idx), 32'd0);
        chk("merge_fail_got", fail_got, 32'h0000_3412);

        // Checked slot never written.
        do_reset();
        exp_data = '0; exp_data[63:32] = 32'hCAFE_0001; exp_data[95:64] = 32'h1234_5678;
        exp_mask = 4'b0110;
        pulse_start();
        store(32'h204, 32'hCAFE_0001, 4'hF);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
        chk("unwr_pass", 32'(pass), 32'd0);
        chk("unwr_idx", 32'(fail_idx), 32'd2);
        chk("unwr_written", 32'(slot_written), 32'b0010);

        // Non-zero exit code with all slots matching; even tohost data is ignored.
        do_reset();
        exp_data = {32'h44, 32'h33, 32'h22, 32'h11}; exp_mask = 4'hF;
        pulse_start();
        store(32'h200, 32'h11, 4'hF);
        store(32'h204, 32'h22, 4'hF);
        store(32'h208, 32'h33, 4'hF);
        store(32'h20C, 32'h44, 4'hF);
        store(32'h3FC, 32'h2, 4'hF);
        chk("even_tohost_ignored", 32'(done), 32'd0);
        store(32'h3FC, 32'h7, 4'hF);
        wait_done(k);
        chk("exit_code_lit", 32'(exit_code), 32'd3);
        chk("exit_pass", 32'(pass), 32'd0);

        // Timeout with no tohost.
        do_reset();
        exp_data = '0; exp_mask = '0;
        pulse_start();
        wait_done(k);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_cycles", cycle_count, 32'd20);
        chk("tmo_pass", 32'(pass), 32'd0);

        // Tohost on the last permitted cycle beats the timeout.
        do_reset();
        pulse_start();
        repeat (19) @(negedge clk);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
        chk("tie_flag", 32'(timeout), 32'd0);
        chk("tie_cycles", cycle_count, 32'd20);
        chk("tie_latency", 32'(k), 32'd5);
        chk("tie_pass", 32'(pass), 32'd1);

        // Reset during CHECK, then a clean restart.
        do_reset();
        exp_data = '0; exp_data[31:0] = 32'h77; exp_mask = 4'b0001;
        pulse_start();
        store(32'h200, 32'h77, 4'hF);
        store(32'h3FC, 32'h1, 4'hF);
        do_reset();
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cycles", cycle_count, 32'd0);
        chk("midrst_written", 32'(slot_written), 32'd0);
        chk("midrst_exit", 32'(exit_code), 32'd0);
        pulse_start();
        store(32'h200, 32'h77, 4'hF);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
        chk("restart_pass", 32'(pass), 32'd1);

        // Store beyond the data memory.
        do_reset();
        exp_data = '0; exp_data[31:0] = 32'h55; exp_mask = 4'b0001;
        pulse_start();
        store(32'h400, 32'hABCD, 4'hF);
`ifdef TEST_MONITOR_OOB_EN
        wait_done(k);
        chk("oob_flag", 32'(oob_err), 32'd1);
        chk("oob_pass", 32'(pass), 32'd0);
        chk("oob_idx", 32'(fail_idx), 32'hF);
        chk("oob_got", fail_got, 32'h400);
`else
        store(32'h200, 32'h55, 4'hF);
        store(32'h3FC, 32'h1, 4'hF);
        wait_done(k);
        chk("oob_flag_off", 32'(oob_err), 32'd0);
        chk("oob_off_pass", 32'(pass), 32'd1);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
